// File: rtl/keycode_tx.sv
// keycode_tx: transmit-side companion to the keypad lock.
// Latches a packed decimal code, strobes it digit-by-digit onto the lock's
// key interface with a programmable inter-digit gap, then watches `locked`
// for confirmation. On no unlock it pulses lock_clear and retries a bounded
// number of times before reporting failure. Codes containing a digit above 9
// are rejected up front with a one-cycle err pulse.
module keycode_tx #(
    parameter int CODE_LEN     = 6,  // digits per code, 1..8
    parameter int GAP_CYCLES   = 2,  // idle cycles between strobes, 0 = back-to-back
    parameter int CHECK_CYCLES = 4,  // cycles allowed for `locked` to fall, >= 1
    parameter int MAX_RETRY    = 2   // extra attempts after the first
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*CODE_LEN-1:0] code,
    input  logic                  locked,
    output logic [3:0]            key,
    output logic                  key_valid,
    output logic                  lock_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic                  err
);

    // Counter widths; each is at least one bit so degenerate parameter
    // values still give legal vectors.
    localparam int IW = (CODE_LEN > 1)     ? $clog2(CODE_LEN)      : 1;
    localparam int GW = (GAP_CYCLES > 1)   ? $clog2(GAP_CYCLES)    : 1;
    localparam int CW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES)  : 1;
    localparam int AW = (MAX_RETRY > 0)    ? $clog2(MAX_RETRY + 1) : 1;

    // Terminal counts. The gap terminal is clamped to 0 when there is no gap,
    // because GAP is never entered in that configuration.
    localparam logic [IW-1:0] IDX_LAST = IW'(CODE_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_CYCLES - 1);
    localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_CHECK,
        S_CLEAR,
        S_DONE,
        S_FAIL,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q,   idx_d;    // digit being sent
    logic [GW-1:0]         gap_q,   gap_d;    // cycles spent in GAP
    logic [CW-1:0]         chk_q,   chk_d;    // `locked` = 1 samples seen in CHECK
    logic [AW-1:0]         att_q,   att_d;    // retries already issued
    logic [4*CODE_LEN-1:0] code_q,  code_d;   // code captured on accepted start

    logic [3:0] cur_digit;
    logic       code_bad;

    // Select the latched digit addressed by idx_q.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        cur_digit = 4'd0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = code_q[4*i +: 4];
            end
        end
    end

    // Flag an incoming code that holds any non-decimal digit.
    always_comb begin
        code_bad = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (code[4*i +: 4] > 4'd9) begin
                code_bad = 1'b1;
            end
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        chk_d   = chk_q;
        att_d   = att_q;
        code_d  = code_q;

        unique case (state_q)
            S_IDLE: begin
                // start is only honoured here; elsewhere it is ignored and
                // the captured code stays untouched for the whole operation.
                if (start) begin
                    if (code_bad) begin
                        state_d = S_ERR;
                    end else begin
                        code_d  = code;
                        idx_d   = '0;
                        att_d   = '0;
                        state_d = S_SEND;
                    end
                end
            end

            S_SEND: begin
                if (idx_q == IDX_LAST) begin
                    chk_d   = '0;
                    state_d = S_CHECK;
                end else if (GAP_CYCLES > 0) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SEND;
                end else begin
                    gap_d   = gap_q + 1'b1;
                end
            end

            S_CHECK: begin
                // A single low sample of `locked` confirms the unlock.
                if (!locked) begin
                    state_d = S_DONE;
                end else if (chk_q == CHK_LAST) begin
                    state_d = (att_q < ATT_MAX) ? S_CLEAR : S_FAIL;
                end else begin
                    chk_d   = chk_q + 1'b1;
                end
            end

            S_CLEAR: begin
                att_d   = att_q + 1'b1;
                idx_d   = '0;
                state_d = S_SEND;
            end

            S_DONE,
            S_FAIL,
            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state, so an asynchronous reset
    // forces every output to 0 at once.
    always_comb begin
        key        = 4'd0;
        key_valid  = 1'b0;
        lock_clear = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        fail       = 1'b0;
        err        = 1'b0;

        unique case (state_q)
            S_SEND: begin
                key       = cur_digit;
                key_valid = 1'b1;
            end
            S_CLEAR: lock_clear = 1'b1;
            S_DONE:  done       = 1'b1;
            S_FAIL:  fail       = 1'b1;
            S_ERR:   err        = 1'b1;
            default: ;
        endcase
    end

    // State and counter registers with asynchronous active-high reset.
    // NOTE: reset sits in the sensitivity list so it takes effect without a
    // clock edge, aborting any operation mid-flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            chk_q   <= '0;
            att_q   <= '0;
            code_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others.
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            chk_q   <= chk_d;
            att_q   <= att_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_keycode_tx.sv
// Testbench for keycode_tx. Stimulus pushes the expected output events
// (strobe digit, clear, done, fail, err, each with its cycle number relative
// to the start-sampling edge) into a queue; a monitor pops and compares on
// every event the DUT presents. Two instances: defaults, and GAP_CYCLES = 0.
module tb_keycode_tx;

    typedef enum logic [2:0] {EV_KEY, EV_CLEAR, EV_DONE, EV_FAIL, EV_ERR} ev_kind_t;

    typedef struct packed {
        ev_kind_t    kind;
        logic [3:0]  digit;
        logic [15:0] cyc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        start_a, start_b;
    logic [23:0] code;
    logic        locked;

    logic [3:0]  key_a, key_b;
    logic        key_valid_a, key_valid_b;
    logic        lock_clear_a, lock_clear_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic        fail_a, fail_b;
    logic        err_a, err_b;

    logic        sel;  // 0 = monitor dut_a, 1 = monitor dut_b
    logic [3:0]  m_key;
    logic        m_key_valid, m_clear, m_done, m_fail, m_err;

    int          edge_cnt = 0;
    int          t0 = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          key_leak = 0;
    ev_t         sb_q[$];

    keycode_tx dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .code       (code),
        .locked     (locked),
        .key        (key_a),
        .key_valid  (key_valid_a),
        .lock_clear (lock_clear_a),
        .busy       (busy_a),
        .done       (done_a),
        .fail       (fail_a),
        .err        (err_a)
    );

    keycode_tx #(
        .CODE_LEN     (6),
        .GAP_CYCLES   (0),
        .CHECK_CYCLES (4),
        .MAX_RETRY    (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .code       (code),
        .locked     (locked),
        .key        (key_b),
        .key_valid  (key_valid_b),
        .lock_clear (lock_clear_b),
        .busy       (busy_b),
        .done       (done_b),
        .fail       (fail_b),
        .err        (err_b)
    );

    assign m_key       = sel ? key_b        : key_a;
    assign m_key_valid = sel ? key_valid_b  : key_valid_a;
    assign m_clear     = sel ? lock_clear_b : lock_clear_a;
    assign m_done      = sel ? done_b       : done_a;
    assign m_fail      = sel ? fail_b       : fail_a;
    assign m_err       = sel ? err_b        : err_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [3:0] d, input int c);
        ev_t e;
        e.kind  = k;
        e.digit = d;
        e.cyc   = 16'(c);
        sb_q.push_back(e);
    endtask

    // Digit strobes of one full attempt whose cycle numbering starts at base.
    task automatic push_attempt(input int base, input logic [23:0] c, input int gap);
        for (int i = 0; i < 6; i++) begin
            expect_ev(EV_KEY, c[4*i +: 4], base + 1 + i * (gap + 1));
        end
    endtask

    task automatic got(input ev_kind_t k, input logic [3:0] d, input int c);
        ev_t act;
        ev_t exp;
        act.kind  = k;
        act.digit = d;
        act.cyc   = 16'(c);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected event: got kind=%0d digit=%0d cycle=%0d, expected none",
                     act.kind, act.digit, act.cyc);
        end else begin
            exp = sb_q.pop_front();
            if (act != exp) begin
                n_fail++;
                $display("FAIL event: got kind=%0d digit=%0d cycle=%0d, expected kind=%0d digit=%0d cycle=%0d",
                         act.kind, act.digit, act.cyc, exp.kind, exp.digit, exp.cyc);
            end
        end
    endtask

    // Monitor: sample the selected DUT mid-cycle and score every event.
    always @(negedge clk) begin : monitor
        int rel;
        if (!reset) begin
            rel = edge_cnt + 1 - t0;
            if (m_key_valid) got(EV_KEY, m_key, rel);
            if (m_clear)     got(EV_CLEAR, 4'd0, rel);
            if (m_done)      got(EV_DONE, 4'd0, rel);
            if (m_fail)      got(EV_FAIL, 4'd0, rel);
            if (m_err)       got(EV_ERR, 4'd0, rel);
            if (!m_key_valid && m_key != 4'd0) key_leak++;
        end
    end

    // Called at a negedge: drive start for one sampling edge; that edge is cycle 0.
    task automatic go_start(input bit which, input logic [23:0] c);
        code = c;
        if (which) start_b = 1'b1;
        else       start_a = 1'b1;
        t0 = edge_cnt + 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Advance to the negedge inside cycle n of the current transaction.
    task automatic at_cycle(input int n);
        int guard = 0;
        while ((edge_cnt + 1 - t0) < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("cycle wait bound", 32'(guard), 32'd0);
    endtask

    task automatic drain(input string name, input int n);
        at_cycle(n);
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int t1_dig [6];
        int t1_cyc [6];
        t1_dig = '{3, 3, 5, 2, 5, 6};
        t1_cyc = '{1, 4, 7, 10, 13, 16};

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        code    = 24'h0;
        locked  = 1'b1;
        sel     = 1'b0;

        #1;
        check("reset outputs a",
              {22'd0, key_a, key_valid_a, lock_clear_a, busy_a, done_a, fail_a, err_a}, 32'd0);
        check("reset outputs b",
              {22'd0, key_b, key_valid_b, lock_clear_b, busy_b, done_b, fail_b, err_b}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: normal unlock, locked falls from cycle 18.
        for (int i = 0; i < 6; i++) expect_ev(EV_KEY, 4'(t1_dig[i]), t1_cyc[i]);
        expect_ev(EV_DONE, 4'd0, 19);
        go_start(1'b0, 24'h652533);
        at_cycle(18);
        locked = 1'b0;
        at_cycle(19);
        check("t1 busy during done", 32'(busy_a), 32'd1);
        locked = 1'b1;
        at_cycle(20);
        check("t1 busy after done", 32'(busy_a), 32'd0);
        drain("t1 scoreboard drained", 24);

        // 2: retries exhausted, locked held high.
        push_attempt(0, 24'h652533, 2);
        expect_ev(EV_CLEAR, 4'd0, 21);
        push_attempt(21, 24'h652533, 2);
        expect_ev(EV_CLEAR, 4'd0, 42);
        push_attempt(42, 24'h652533, 2);
        expect_ev(EV_FAIL, 4'd0, 63);
        go_start(1'b0, 24'h652533);
        at_cycle(63);
        check("t2 busy during fail", 32'(busy_a), 32'd1);
        at_cycle(64);
        check("t2 busy after fail", 32'(busy_a), 32'd0);
        drain("t2 scoreboard drained", 68);

        // 3: invalid digit rejected.
        expect_ev(EV_ERR, 4'd0, 1);
        go_start(1'b0, 24'h65A533);
        at_cycle(1);
        check("t3 busy during err", 32'(busy_a), 32'd1);
        at_cycle(2);
        check("t3 busy after err", 32'(busy_a), 32'd0);
        drain("t3 scoreboard drained", 24);

        // 4: reset during the digit-2 strobe of the first retry, then replay.
        push_attempt(0, 24'h652533, 2);
        expect_ev(EV_CLEAR, 4'd0, 21);
        expect_ev(EV_KEY, 4'd3, 22);
        expect_ev(EV_KEY, 4'd3, 25);
        go_start(1'b0, 24'h652533);
        at_cycle(27);
        @(posedge clk);
        #1;
        check("t4 strobe before reset", {27'd0, key_valid_a, key_a}, {27'd0, 1'b1, 4'h5});
        reset = 1'b1;
        #1;
        check("t4 outputs on reset",
              {22'd0, key_a, key_valid_a, lock_clear_a, busy_a, done_a, fail_a, err_a}, 32'd0);
        repeat (2) @(negedge clk);
        check("t4 outputs held in reset",
              {22'd0, key_a, key_valid_a, lock_clear_a, busy_a, done_a, fail_a, err_a}, 32'd0);
        check("t4 scoreboard before replay", 32'(sb_q.size()), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        push_attempt(0, 24'h652533, 2);
        expect_ev(EV_CLEAR, 4'd0, 21);
        push_attempt(21, 24'h652533, 2);
        expect_ev(EV_CLEAR, 4'd0, 42);
        push_attempt(42, 24'h652533, 2);
        expect_ev(EV_FAIL, 4'd0, 63);
        go_start(1'b0, 24'h652533);
        at_cycle(64);
        check("t4 busy after replay", 32'(busy_a), 32'd0);
        drain("t4 scoreboard drained", 68);

        // 5: back-to-back strobes, ignored start, restart on first IDLE edge.
        sel    = 1'b1;
        locked = 1'b0;
        for (int i = 0; i < 6; i++) expect_ev(EV_KEY, t1_dig[i][3:0], i + 1);
        expect_ev(EV_DONE, 4'd0, 8);
        go_start(1'b1, 24'h652533);
        at_cycle(3);
        code    = 24'h111111;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        at_cycle(8);
        check("t5 busy during done", 32'(busy_b), 32'd1);
        at_cycle(9);
        check("t5 busy after done", 32'(busy_b), 32'd0);
        expect_ev(EV_KEY, 4'd9, 1);
        expect_ev(EV_KEY, 4'd0, 2);
        expect_ev(EV_KEY, 4'd0, 3);
        expect_ev(EV_KEY, 4'd7, 4);
        expect_ev(EV_KEY, 4'd8, 5);
        expect_ev(EV_KEY, 4'd9, 6);
        expect_ev(EV_DONE, 4'd0, 8);
        go_start(1'b1, 24'h987009);
        at_cycle(9);
        check("t5 busy after second done", 32'(busy_b), 32'd0);
        drain("t5 scoreboard drained", 12);

        check("key zero while not valid", 32'(key_leak), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keycode_tx.md
# keycode_tx

Transmit-side companion to the keypad lock. Latches a packed multi-digit code and drives it digit-by-digit onto the lock's key interface as single-cycle strobes with a programmable inter-digit gap. It then watches the lock's `locked` status for confirmation. If the lock does not open, it issues a clear pulse and retries a bounded number of times before reporting failure. Used by the test/maintenance path to open the lock automatically.

## Interface

**Parameters**
- `CODE_LEN`, default 6: number of decimal digits per code, range 1–8.
- `GAP_CYCLES`, default 2: idle cycles between digit strobes; 0 gives back-to-back strobes.
- `CHECK_CYCLES`, default 4: cycles allowed after the last digit for `locked` to fall; must be ≥1.
- `MAX_RETRY`, default 2: extra attempts after the first.

**Ports**
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: reset, asynchronous, active-high.
- `start`  input  1: one-cycle request; sampled only in IDLE.
- `code`  input  `4*CODE_LEN`: packed digits; digit 0 is `code[3:0]` and is sent first. Latched on accepted `start`.
- `locked`  input  1: lock status, 1 = locked.
- `key`  output  4: current digit; 0 whenever `key_valid` = 0.
- `key_valid`  output  1: one-cycle strobe per digit.
- `lock_clear`  output  1: one-cycle pulse that returns the lock to its initial state before a retry.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: one-cycle pulse, unlock confirmed.
- `fail`  output  1: one-cycle pulse, retries exhausted.
- `err`  output  1: one-cycle pulse, rejected code (any digit > 9).

## Operation

- **States:** IDLE, SEND, GAP, CHECK, CLEAR, DONE, FAIL, ERR.
- **Registers:**
  - digit index `idx`, 0..CODE_LEN-1
  - gap counter
  - check counter
  - attempt counter, 0..MAX_RETRY
  - latched code
- **IDLE**
  - `start` = 1 with all digits ≤ 9: latch `code`, `idx` = 0, attempt = 0, go to SEND.
  - `start` = 1 with any digit > 9: go to ERR.
  - `start` = 0: stay.
- **SEND:** `key` = digit[`idx`], `key_valid` = 1 for exactly this cycle.
  - `idx` = CODE_LEN-1: go to CHECK, check counter = 0.
  - Otherwise, GAP_CYCLES > 0: go to GAP.
  - Otherwise (GAP_CYCLES = 0): go to SEND with `idx` + 1.
- **GAP:** stays GAP_CYCLES cycles with `key` = 0 and `key_valid` = 0, then SEND with `idx` + 1.
- **CHECK:** samples `locked` each cycle.
  - `locked` = 0: go to DONE.
  - After CHECK_CYCLES samples of 1: if attempt < MAX_RETRY, go to CLEAR; otherwise go to FAIL.
- **CLEAR:** `lock_clear` = 1 for one cycle, attempt + 1, `idx` = 0, then SEND.
- **DONE / FAIL / ERR:** assert `done` / `fail` / `err` for one cycle respectively, then IDLE.
- `start` outside IDLE is ignored; the latched code is never modified mid-operation.
- `locked` is ignored outside CHECK.

## Timing

- **Reset values:** all outputs 0, state IDLE, all counters 0, latched code 0.
- Reset asserted mid-operation aborts immediately (asynchronous); no `done`, `fail` or `err` is produced.
- Cycle numbering: the `start` sampling edge is cycle 0.
- Digit i strobes in cycle 1 + i·(GAP_CYCLES+1).
- First CHECK cycle = cycle after the last strobe.
- `done` is asserted the cycle after the CHECK cycle in which `locked` = 0 is sampled.
- Retry: CLEAR occupies one cycle; digit 0 strobes the next cycle.
- `err` is asserted in cycle 1; `busy` is high only during that cycle.
- `busy` rises in cycle 1 and falls in the cycle after the `done`/`fail`/`err` pulse.
- A new `start` is accepted on the first IDLE edge.

## Test plan

1. **Normal unlock:** `code` = 0x652533, defaults; `locked` driven 0 from cycle 18 → `key_valid` strobes 3,3,5,2,5,6 in cycles 1,4,7,10,13,16; `done` in cycle 19; no `lock_clear`.
2. **Retries exhausted:** same code, `locked` held at 1 → CHECK cycles 17–20, `lock_clear` in cycle 21, digit 0 again in cycle 22. Three full digit sequences in total, two `lock_clear` pulses, `fail` one cycle after the last CHECK cycle, then `busy` = 0.
3. **Invalid digit:** `code` = 0x65A533 → `err` in cycle 1; no `key_valid`, no `lock_clear`, no `done`.
4. **Reset mid-operation:** assert `reset` during the digit-2 strobe → all outputs 0 immediately. A following `start` replays from digit 0 with attempt count 0.
5. **Back-to-back and ignored start:** GAP_CYCLES = 0, CODE_LEN = 6 → strobes in cycles 1–6 with no idle between them. A second `start` pulse in cycle 3 with a different code is ignored; the original digits are still sent.
